// File: rtl/vga_dvid_pkg.sv
// Shared constants and helpers for the TMDS encoder: control tokens,
// running-disparity width and an 8-bit popcount.
package vga_dvid_pkg;

  localparam int CNT_W = 5;
  localparam int EXT_W = CNT_W + 2;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: transition minimisation (stage 1) followed by DC balance
// with a signed running disparity and the control-token mux (stage 2).
module tmds_channel
  import vga_dvid_pkg::*;
(
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] data,
  input  logic [1:0] c,
  input  logic       blank,
  output logic [9:0] out
);

  localparam logic signed [EXT_W-1:0] ZERO_E    = '0;
  localparam logic signed [EXT_W-1:0] TWO_E     = 7'sd2;
  localparam logic signed [EXT_W-1:0] CNT_LIM   = 7'sd10;
  localparam logic signed [EXT_W-1:0] CNT_LIM_N = -7'sd10;

  function automatic logic [9:0] ctrl_token(input logic [1:0] cc);
    case (cc)
      2'b00:   return TOK_00;
      2'b01:   return TOK_01;
      2'b10:   return TOK_10;
      default: return TOK_11;
    endcase
  endfunction

  logic [3:0] w_n1_d;
  logic       w_use_xnor;
  logic [8:0] w_qm;

  always_comb begin
    w_n1_d     = popcount8(data);
    w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !data[0]);
    w_qm       = '0;
    w_qm[0]    = data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ data[i]) : (w_qm[i-1] ^ data[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  // Stage 1 boundary: q_m plus the controls that travel with it
  logic [8:0] r_qm_p0;
  logic       r_blank_p0;
  logic [1:0] r_c_p0;
  logic       r_vld_p0;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_qm_p0    <= '0;
      r_blank_p0 <= 1'b0;
      r_c_p0     <= '0;
      r_vld_p0   <= 1'b0;
    end else if (ce) begin
      r_qm_p0    <= w_qm;
      r_blank_p0 <= blank;
      r_c_p0     <= c;
      r_vld_p0   <= 1'b1;
    end
  end

  logic signed [CNT_W-1:0] r_cnt_p1;
  logic [9:0]              r_out_p1;
  logic [3:0]              w_n1_q;
  logic                    w_q8;
  logic [7:0]              w_qm8;
  logic signed [EXT_W-1:0] w_disp;
  logic signed [EXT_W-1:0] w_cnt_ext;
  logic signed [EXT_W-1:0] w_cnt_next;
  logic [9:0]              w_sym;

  always_comb begin
    w_n1_q     = popcount8(r_qm_p0[7:0]);
    w_q8       = r_qm_p0[8];
    w_qm8      = r_qm_p0[7:0];
    w_disp     = $signed(EXT_W'({w_n1_q, 1'b0})) - $signed(EXT_W'(8));
    w_cnt_ext  = EXT_W'(r_cnt_p1);
    w_cnt_next = w_cnt_ext;
    w_sym      = r_out_p1;
    if ((w_cnt_ext == ZERO_E) || (w_disp == ZERO_E)) begin
      w_sym      = {~w_q8, w_q8, (w_q8 ? w_qm8 : ~w_qm8)};
      w_cnt_next = w_q8 ? (w_cnt_ext + w_disp) : (w_cnt_ext - w_disp);
    end else if (((w_cnt_ext > ZERO_E) && (w_disp > ZERO_E)) ||
                 ((w_cnt_ext < ZERO_E) && (w_disp < ZERO_E))) begin
      w_sym      = {1'b1, w_q8, ~w_qm8};
      w_cnt_next = w_cnt_ext + (w_q8 ? TWO_E : ZERO_E) - w_disp;
    end else begin
      w_sym      = {1'b0, w_q8, w_qm8};
      w_cnt_next = w_cnt_ext + w_disp - (w_q8 ? ZERO_E : TWO_E);
    end
  end

  // Stage 2 boundary: balanced symbol and running disparity; a blank forces cnt to 0
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_out_p1 <= '0;
      r_cnt_p1 <= '0;
    end else if (ce && r_vld_p0) begin
      if (r_blank_p0) begin
        r_out_p1 <= ctrl_token(r_c_p0);
        r_cnt_p1 <= '0;
      end else begin
        assert ((w_cnt_next <= CNT_LIM) && (w_cnt_next >= CNT_LIM_N));
        r_out_p1 <= w_sym;
        r_cnt_p1 <= w_cnt_next[CNT_W-1:0];
      end
    end
  end

  assign out = r_out_p1;

endmodule

// File: rtl/tmds_encoder_rgb.sv
// Three-channel TMDS encoder: expands colour depth by MSB replication, maps
// sync polarities onto the blue channel's control bits and encodes each channel.
module tmds_encoder_rgb
  import vga_dvid_pkg::*;
#(
  parameter int   C_depth     = 8,
  parameter logic C_hsync_pol = 1'b1,
  parameter logic C_vsync_pol = 1'b1
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic               ce,
  input  logic [C_depth-1:0] in_red,
  input  logic [C_depth-1:0] in_green,
  input  logic [C_depth-1:0] in_blue,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_blank,
  output logic [9:0]         out_red,
  output logic [9:0]         out_green,
  output logic [9:0]         out_blue
);

  logic [7:0] w_red8;
  logic [7:0] w_green8;
  logic [7:0] w_blue8;
  logic       w_hs_act;
  logic       w_vs_act;

  // Bit 7-i of the expanded value repeats the input pattern MSB first
  for (genvar i = 0; i < 8; i++) begin : g_expand
    assign w_red8[7-i]   = in_red[C_depth-1-(i % C_depth)];
    assign w_green8[7-i] = in_green[C_depth-1-(i % C_depth)];
    assign w_blue8[7-i]  = in_blue[C_depth-1-(i % C_depth)];
  end

  assign w_hs_act = (in_hsync == C_hsync_pol);
  assign w_vs_act = (in_vsync == C_vsync_pol);

  tmds_channel u_red (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .ce        (ce),
    .data      (w_red8),
    .c         (2'b00),
    .blank     (in_blank),
    .out       (out_red)
  );

  tmds_channel u_green (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .ce        (ce),
    .data      (w_green8),
    .c         (2'b00),
    .blank     (in_blank),
    .out       (out_green)
  );

  tmds_channel u_blue (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .ce        (ce),
    .data      (w_blue8),
    .c         ({w_vs_act, w_hs_act}),
    .blank     (in_blank),
    .out       (out_blue)
  );

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// Bench for tmds_encoder_rgb: depth-8 and depth-3/inverted-hsync instances
// driven in lockstep and checked against a behavioural TMDS model.
module tb_tmds_encoder_rgb;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] S0  = 10'b0100000000;
  localparam logic [9:0] S1  = 10'b1111111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce;
  logic [7:0] r, g, b;
  logic       hs, vs, blank;
  logic [9:0] o_r8, o_g8, o_b8, o_r3, o_g3, o_b3;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  tmds_encoder_rgb #(.C_depth(8), .C_hsync_pol(1'b1), .C_vsync_pol(1'b1)) dut (
    .clk_pixel(clk), .reset(rst), .ce(ce),
    .in_red(r), .in_green(g), .in_blue(b),
    .in_hsync(hs), .in_vsync(vs), .in_blank(blank),
    .out_red(o_r8), .out_green(o_g8), .out_blue(o_b8)
  );

  tmds_encoder_rgb #(.C_depth(3), .C_hsync_pol(1'b0), .C_vsync_pol(1'b1)) dut3 (
    .clk_pixel(clk), .reset(rst), .ce(ce),
    .in_red(r[2:0]), .in_green(g[2:0]), .in_blue(b[2:0]),
    .in_hsync(hs), .in_vsync(vs), .in_blank(blank),
    .out_red(o_r3), .out_green(o_g3), .out_blue(o_b3)
  );

  // ---------------- behavioural model ----------------
  logic [9:0] TOK [4] = '{T00, T01, T10, T11};
  int         depth_of [2] = '{8, 3};
  bit         hpol [2] = '{1'b1, 1'b0};
  bit         vpol [2] = '{1'b1, 1'b1};
  int         m_cnt [2][3];
  logic [9:0] m_out [2][3];
  bit         pv;
  int         p_rgb [3];
  bit         p_blank, p_hs, p_vs;

  function automatic int expand(input int v, input int depth);
    int acc = 0;
    int len = 0;
    int vv  = v & ((1 << depth) - 1);
    while (len < 8) begin
      acc = (acc << depth) | vv;
      len += depth;
    end
    return (acc >> (len - 8)) & 255;
  endfunction

  task automatic enc(input int d, input bit bl, input int tk, input int cnt_in,
                     output logic [9:0] sym, output int cnt_out);
    logic [7:0] dd, qm;
    int n1, m1, diff, q8;
    bit use_xnor;
    if (bl) begin
      sym = TOK[tk];
      cnt_out = 0;
    end else begin
      dd = d[7:0];
      n1 = $countones(dd);
      use_xnor = (n1 > 4) || (n1 == 4 && dd[0] == 1'b0);
      qm[0] = dd[0];
      for (int i = 1; i < 8; i++)
        qm[i] = use_xnor ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
      q8 = use_xnor ? 0 : 1;
      m1 = $countones(qm);
      diff = m1 - (8 - m1);
      if (cnt_in == 0 || diff == 0) begin
        sym = (q8 == 1) ? {2'b01, qm} : {2'b10, ~qm};
        cnt_out = cnt_in + ((q8 == 1) ? diff : -diff);
      end else if ((cnt_in > 0 && diff > 0) || (cnt_in < 0 && diff < 0)) begin
        sym = {1'b1, q8[0], ~qm};
        cnt_out = cnt_in + 2 * q8 - diff;
      end else begin
        sym = {1'b0, q8[0], qm};
        cnt_out = cnt_in + diff - 2 * (1 - q8);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < 3; ch++) begin
        m_cnt[k][ch] = 0;
        m_out[k][ch] = '0;
      end
    pv = 1'b0;
  endtask

  task automatic model_step();
    logic [9:0] sym;
    int nc, tk;
    if (pv) begin
      for (int k = 0; k < 2; k++)
        for (int ch = 0; ch < 3; ch++) begin
          tk = 0;
          if (ch == 2) tk = ((p_vs == vpol[k]) ? 2 : 0) + ((p_hs == hpol[k]) ? 1 : 0);
          enc(expand(p_rgb[ch], depth_of[k]), p_blank, tk, m_cnt[k][ch], sym, nc);
          m_out[k][ch] = sym;
          m_cnt[k][ch] = nc;
        end
    end
    p_rgb[0] = int'(r); p_rgb[1] = int'(g); p_rgb[2] = int'(b);
    p_blank = blank; p_hs = hs; p_vs = vs;
    pv = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst && ce) model_step();
    @(negedge clk);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [9:0] act [2][3];
    int acnt [3];
    wait (started);
    forever begin
      @(negedge clk);
      act[0][0] = o_r8; act[0][1] = o_g8; act[0][2] = o_b8;
      act[1][0] = o_r3; act[1][1] = o_g3; act[1][2] = o_b3;
      acnt[0] = dut.u_red.r_cnt_p1;
      acnt[1] = dut.u_green.r_cnt_p1;
      acnt[2] = dut.u_blue.r_cnt_p1;
      for (int k = 0; k < 2; k++)
        for (int ch = 0; ch < 3; ch++)
          chk($sformatf("out_k%0d_ch%0d", k, ch), int'(act[k][ch]), int'(m_out[k][ch]));
      for (int ch = 0; ch < 3; ch++) begin
        chk($sformatf("cnt_ch%0d", ch), acnt[ch], m_cnt[0][ch]);
        chk($sformatf("cnt_bound_ch%0d", ch), (acnt[ch] <= 10 && acnt[ch] >= -10) ? 1 : 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] exp8 [4] = '{T00, T01, T10, T11};
  logic [9:0] exp3 [4] = '{T01, T00, T11, T10};
  bit         hs_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit         vs_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  bit         ce_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [9:0] ce_sym [6] = '{T00, T00, T00, S0, S1, S0};
  int         ce_cnt [6] = '{0, 0, 0, -8, 2, -6};

  initial begin
    ce = 1'b1; r = 8'h5A; g = 8'hC3; b = 8'h0F; hs = 1'b1; vs = 1'b0; blank = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("reset_out_blue", int'(o_b8), 0);
    chk("reset_out_red3", int'(o_r3), 0);
    chk("reset_cnt_blue", int'(dut.u_blue.r_cnt_p1), 0);
    started = 1'b1;
    repeat (2) begin
      @(negedge clk);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); hs = ~hs; blank = ~blank;
    end
    @(negedge clk);
    rst = 1'b0;

    // First symbol after release
    blank = 1'b1; hs = 1'b0; vs = 1'b0;
    cyc(); cyc();
    chk("post_reset_token", int'(o_b8), int'(T00));

    // Control tokens for every sync combination
    for (int i = 0; i < 4; i++) begin
      hs = hs_t[i]; vs = vs_t[i];
      cyc(); cyc();
      chk($sformatf("token_blue_%0d", i), int'(o_b8), int'(exp8[i]));
      chk($sformatf("token_blue_hpol0_%0d", i), int'(o_b3), int'(exp3[i]));
      chk($sformatf("token_red_%0d", i), int'(o_r8), int'(T00));
      chk($sformatf("token_green_%0d", i), int'(o_g8), int'(T00));
    end

    // DC balance on a run of blue 0x00
    hs = 1'b0; vs = 1'b0; blank = 1'b1;
    cyc(); cyc();
    blank = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
    cyc(); cyc();
    chk("dc_sym0", int'(o_b8), int'(S0));
    chk("dc_cnt0", int'(dut.u_blue.r_cnt_p1), -8);
    cyc();
    chk("dc_sym1", int'(o_b8), int'(S1));
    chk("dc_cnt1", int'(dut.u_blue.r_cnt_p1), 2);
    cyc();
    chk("dc_sym2", int'(o_b8), int'(S0));
    chk("dc_cnt2", int'(dut.u_blue.r_cnt_p1), -6);

    // Depth-3 replication
    r = 8'h05;
    #1;
    chk("depth3_expand", int'(dut3.w_red8), 'hB6);
    chk("model_expand", expand(5, 3), 'hB6);
    cyc();

    // Clock-enable gating
    blank = 1'b1; hs = 1'b0; vs = 1'b0;
    cyc(); cyc();
    blank = 1'b0; b = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ce = ce_seq[i];
      cyc();
      chk($sformatf("ce_sym_%0d", i), int'(o_b8), int'(ce_sym[i]));
      chk($sformatf("ce_cnt_%0d", i), int'(dut.u_blue.r_cnt_p1), ce_cnt[i]);
    end
    ce = 1'b1;

    // Reset in the middle of an active line
    blank = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      cyc();
    end
    @(posedge clk);
    if (ce) model_step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midreset_out_blue", int'(o_b8), 0);
    chk("midreset_out_green", int'(o_g8), 0);
    chk("midreset_cnt_blue", int'(dut.u_blue.r_cnt_p1), 0);
    @(negedge clk);
    r = 8'($urandom); b = 8'($urandom); hs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    blank = 1'b1; hs = 1'b0; vs = 1'b0;
    cyc(); cyc();
    blank = 1'b0; b = 8'h00;
    cyc(); cyc();
    chk("midreset_first_pixel", int'(o_b8), int'(S0));
    chk("midreset_first_cnt", int'(dut.u_blue.r_cnt_p1), -8);

    // Randomised traffic
    for (int i = 0; i < 10000; i++) begin
      ce = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) blank = ~blank;
      hs = 1'($urandom); vs = 1'($urandom);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
